// File: rtl/gray_bcd_scan_driver.sv
// gray_bcd_scan_driver: samples a Gray-coded value on a strobe, converts it to
// binary and then to packed BCD with a sequential shift-add-3 engine, and
// drives a multiplexed common-anode seven-segment display through a refresh
// scanner.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blanks leading zero digits).
module gray_bcd_scan_driver #(
  parameter int WIDTH       = 4,
  parameter int DIGITS      = 2,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  gray_in,
  input  logic              load,
  output logic              busy,
  output logic              valid,
  output logic [DIGITS-1:0] anodo,
  output logic [7:0]        catodo
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] gray_bin;
  logic [WIDTH-1:0] bin_sr;
  logic [BCD_W-1:0] bcd_sr;
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] disp;
  logic [CNT_W-1:0] bit_cnt;
  logic [REF_W-1:0] ref_cnt;
  logic [IDX_W-1:0] digit_idx;
  logic [3:0]       cur_nibble;
  logic             blank;

  // Seven-segment pattern for one BCD nibble, segments a..g, active low.
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0:    seg_of = 7'b0000001;
      4'd1:    seg_of = 7'b1001111;
      4'd2:    seg_of = 7'b0010010;
      4'd3:    seg_of = 7'b0000110;
      4'd4:    seg_of = 7'b1001100;
      4'd5:    seg_of = 7'b0100100;
      4'd6:    seg_of = 7'b0100000;
      4'd7:    seg_of = 7'b0001111;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0000100;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    gray_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      gray_bin[i] = ^(gray_in >> i);
    end
  end

  // Add-3 correction: every BCD nibble of 5 or more is bumped before the shift.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_sr[4*d +: 4] >= 4'd5) begin
        bcd_adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM: accept a load, run WIDTH shift steps, publish the result.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      valid   <= 1'b0;
      disp    <= '0;
      bin_sr  <= '0;
      bcd_sr  <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            bin_sr  <= gray_bin;
            bcd_sr  <= '0;
            bit_cnt <= CNT_W'(WIDTH);
            busy    <= 1'b1;
            state   <= CONVERT;
          end
        end
        CONVERT: begin
          {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
          bit_cnt          <= bit_cnt - 1'b1;
          if (bit_cnt == CNT_W'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          disp  <= bcd_sr;
          valid <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Refresh scanner: hold each digit for REFRESH_DIV cycles, then advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_cnt   <= '0;
      digit_idx <= '0;
    end else if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
      ref_cnt   <= '0;
      digit_idx <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + 1'b1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  // Select the nibble of the digit currently being scanned.
  always_comb begin
    cur_nibble = 4'd0;
    for (int d = 0; d < DIGITS; d++) begin
      if (digit_idx == IDX_W'(d)) begin
        cur_nibble = disp[4*d +: 4];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Blank zero digits above the most significant nonzero digit; digit 0 always shows.
  always_comb begin
    logic seen_nz;
    seen_nz = 1'b0;
    blank   = 1'b0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      if (disp[4*d +: 4] != 4'd0) begin
        seen_nz = 1'b1;
      end
      if ((digit_idx == IDX_W'(d)) && (d != 0) && !seen_nz) begin
        blank = 1'b1;
      end
    end
  end
`else
  // Every digit displays its nibble, leading zeros included.
  always_comb begin
    blank = 1'b0;
  end
`endif

  // Registered pin drivers: one-hot-low anode and the matching cathode pattern.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      anodo  <= ~DIGITS'(1);
      catodo <= 8'b1000_0001;
    end else begin
      anodo  <= ~(DIGITS'(1) << digit_idx);
      catodo <= {1'b1, blank ? 7'b1111111 : seg_of(cur_nibble)};
    end
  end

endmodule

// File: tb/tb_gray_bcd_scan_driver.sv
// Testbench for gray_bcd_scan_driver: two instances (4-bit/2-digit and
// 8-bit/3-digit). Stimulus pushes hand-computed cathode patterns into
// queues; per-instance monitors pop them when a conversion completes and
// compare against what the scanner shows on the pins.
module tb_gray_bcd_scan_driver;

  localparam int W_A = 4, D_A = 2, R_A = 3;
  localparam int W_B = 8, D_B = 3, R_B = 4;

  // Cathode bytes (dp=1, a..g active low) for digits 0..9.
  localparam logic [7:0] S0 = 8'h81, S1 = 8'hCF, S2 = 8'h92, S3 = 8'h86, S4 = 8'hCC;
  localparam logic [7:0] S5 = 8'hA4, S6 = 8'hA0, S7 = 8'h8F, S8 = 8'h80, S9 = 8'h84;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LZ = 8'hFF;
`else
  localparam logic [7:0] LZ = S0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W_A-1:0] gray_a = '0;
  logic           load_a = 1'b0;
  logic           busy_a, valid_a;
  logic [D_A-1:0] anodo_a;
  logic [7:0]     catodo_a;
  logic [W_B-1:0] gray_b = '0;
  logic           load_b = 1'b0;
  logic           busy_b, valid_b;
  logic [D_B-1:0] anodo_b;
  logic [7:0]     catodo_b;

  int total = 0;
  int bad   = 0;
  int done_a = 0;
  int done_b = 0;

  logic [8*D_A-1:0] q_a[$];
  logic [8*D_B-1:0] q_b[$];

  always #5 clk = ~clk;

  gray_bcd_scan_driver #(.WIDTH(W_A), .DIGITS(D_A), .REFRESH_DIV(R_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_a), .load(load_a),
    .busy(busy_a), .valid(valid_a), .anodo(anodo_a), .catodo(catodo_a)
  );

  gray_bcd_scan_driver #(.WIDTH(W_B), .DIGITS(D_B), .REFRESH_DIV(R_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_b), .load(load_b),
    .busy(busy_b), .valid(valid_b), .anodo(anodo_b), .catodo(catodo_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor A: on each completed conversion, check busy length and valid,
  // then capture every scanned digit and compare with the queued patterns.
  initial begin : mon_a
    int busy_len;
    logic prev_busy;
    logic [8*D_A-1:0] got, exp;
    logic [D_A-1:0] seen;
    busy_len = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_len = 0;
        prev_busy = 1'b0;
      end else if (busy_a) begin
        busy_len++;
        prev_busy = 1'b1;
      end else if (prev_busy) begin
        prev_busy = 1'b0;
        check("a_busy_len", busy_len, W_A + 1);
        check("a_valid", {31'd0, valid_a}, 1);
        busy_len = 0;
        got = '0;
        seen = '0;
        for (int c = 0; c < 2 * D_A * R_A; c++) begin
          @(negedge clk);
          for (int d = 0; d < D_A; d++) begin
            if (anodo_a == ~(D_A'(1) << d)) begin
              got[8*d +: 8] = catodo_a;
              seen[d] = 1'b1;
            end
          end
        end
        check("a_digits_scanned", {30'd0, seen}, 32'h3);
        if (q_a.size() == 0) begin
          total++;
          bad++;
          $display("FAIL a_unexpected_result: got %0h, expected no conversion", got);
        end else begin
          exp = q_a.pop_front();
          check("a_display", {16'd0, got}, {16'd0, exp});
        end
        done_a++;
      end
    end
  end

  // Monitor B: same scheme for the three-digit instance.
  initial begin : mon_b
    int busy_len;
    logic prev_busy;
    logic [8*D_B-1:0] got, exp;
    logic [D_B-1:0] seen;
    busy_len = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_len = 0;
        prev_busy = 1'b0;
      end else if (busy_b) begin
        busy_len++;
        prev_busy = 1'b1;
      end else if (prev_busy) begin
        prev_busy = 1'b0;
        check("b_busy_len", busy_len, W_B + 1);
        check("b_valid", {31'd0, valid_b}, 1);
        busy_len = 0;
        got = '0;
        seen = '0;
        for (int c = 0; c < 2 * D_B * R_B; c++) begin
          @(negedge clk);
          for (int d = 0; d < D_B; d++) begin
            if (anodo_b == ~(D_B'(1) << d)) begin
              got[8*d +: 8] = catodo_b;
              seen[d] = 1'b1;
            end
          end
        end
        check("b_digits_scanned", {29'd0, seen}, 32'h7);
        if (q_b.size() == 0) begin
          total++;
          bad++;
          $display("FAIL b_unexpected_result: got %0h, expected no conversion", got);
        end else begin
          exp = q_b.pop_front();
          check("b_display", {8'd0, got}, {8'd0, exp});
        end
        done_b++;
      end
    end
  end

  task automatic wait_done_a(input int target, input string name);
    int n;
    n = 0;
    while (done_a < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (done_a < target) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d results, expected %0d", name, done_a, target);
    end
  endtask

  task automatic wait_done_b(input int target, input string name);
    int n;
    n = 0;
    while (done_b < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (done_b < target) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d results, expected %0d", name, done_b, target);
    end
  endtask

  // One load pulse on instance A; gray_in is scrambled right after acceptance.
  task automatic conv_a(input logic [W_A-1:0] g, input logic [8*D_A-1:0] exp, input string name);
    int target;
    target = done_a + 1;
    q_a.push_back(exp);
    @(negedge clk);
    gray_a = g;
    load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    gray_a = ~g;
    wait_done_a(target, name);
  endtask

  task automatic conv_b(input logic [W_B-1:0] g, input logic [8*D_B-1:0] exp, input string name);
    int target;
    target = done_b + 1;
    q_b.push_back(exp);
    @(negedge clk);
    gray_b = g;
    load_b = 1'b1;
    @(negedge clk);
    load_b = 1'b0;
    gray_b = ~g;
    wait_done_b(target, name);
  endtask

  // Measure how long instance B keeps the current anode pattern and what follows.
  task automatic scan_step_b(input logic [D_B-1:0] next_exp, input string name);
    logic [D_B-1:0] prev;
    int n;
    prev = anodo_b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (anodo_b == prev && n < 50);
    check({name, "_len"}, n, R_B);
    check({name, "_anodo"}, {29'd0, anodo_b}, {29'd0, next_exp});
  endtask

  initial begin : stim
    int target;
    int n;
    logic [8*D_A-1:0] got;

    // Reset held for three cycles.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy_a}, 0);
    check("rst_valid", {31'd0, valid_a}, 0);
    check("rst_anodo_a", {30'd0, anodo_a}, 32'h2);
    check("rst_catodo_a", {24'd0, catodo_a}, 32'h81);
    check("rst_anodo_b", {29'd0, anodo_b}, 32'h6);
    rst_n = 1'b1;

    // Scanner rotation on instance B: 110 -> 101 -> 011 -> 110, four cycles each.
    n = 0;
    while (anodo_b == 3'b110 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("b_scan_first_step", {29'd0, anodo_b}, 32'h5);
    scan_step_b(3'b011, "b_scan_d1");
    scan_step_b(3'b110, "b_scan_wrap");

    // Instance B conversions: 255 and 100.
    conv_b(8'b1000_0000, {S2, S5, S5}, "b_255");
    conv_b(8'b0101_0110, {S1, S0, S0}, "b_100");

    // Instance A directed vectors (Gray -> value -> digits).
    conv_a(4'b1000, {S1, S5}, "a_15");
    conv_a(4'b1111, {S1, S0}, "a_10");
    conv_a(4'b0000, {LZ, S0}, "a_0");
    conv_a(4'b0110, {LZ, S4}, "a_4");
    conv_a(4'b1101, {LZ, S9}, "a_9");
    conv_a(4'b0100, {LZ, S7}, "a_7");
    conv_a(4'b1100, {LZ, S8}, "a_8");
    conv_a(4'b0011, {LZ, S2}, "a_2");
    conv_a(4'b0010, {LZ, S3}, "a_3");
    conv_a(4'b0101, {LZ, S6}, "a_6");
    conv_a(4'b1010, {S1, S2}, "a_12");
    conv_a(4'b1011, {S1, S3}, "a_13");

    // Second load two cycles into a conversion is ignored.
    target = done_a + 1;
    q_a.push_back({LZ, S1});
    @(negedge clk);
    gray_a = 4'b0001;
    load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    @(negedge clk);
    gray_a = 4'b1000;
    load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    wait_done_a(target, "a_ignore");
    repeat (4) @(negedge clk);
    check("a_ignore_idle", {31'd0, busy_a}, 0);

    // Reset two cycles into a conversion aborts it and clears the display.
    @(negedge clk);
    gray_a = 4'b1000;
    load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy_a}, 0);
    check("abort_valid", {31'd0, valid_a}, 0);
    check("abort_anodo", {30'd0, anodo_a}, 32'h2);
    check("abort_catodo", {24'd0, catodo_a}, 32'h81);
    rst_n = 1'b1;
    got = '0;
    for (int c = 0; c < 2 * D_A * R_A + 2; c++) begin
      @(negedge clk);
      for (int d = 0; d < D_A; d++) begin
        if (anodo_a == ~(D_A'(1) << d)) got[8*d +: 8] = catodo_a;
      end
    end
    check("abort_display", {16'd0, got}, {16'd0, LZ, S0});
    check("abort_no_busy", {31'd0, busy_a}, 0);

    // A normal conversion after the abort.
    conv_a(4'b1000, {S1, S5}, "a_after_abort");

    check("a_queue_empty", q_a.size(), 0);
    check("b_queue_empty", q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
